// File: rtl/can_destuffer_if.sv
// Bit-stream link between the baud sampler/frame parser and the CAN destuffer.
// The master drives sampled bits, and the slave returns destuffed bits and bus status.
interface can_destuffer_if;
  logic       bit_in;
  logic       bit_valid;
  logic       stuff_stop;
  logic       out_bit;
  logic       out_valid;
  logic       sof;
  logic       stuff_err;
  logic       bus_idle;
  logic       frame_active;
  logic [7:0] stuff_cnt;

  modport master (
    output bit_in, bit_valid, stuff_stop,
    input  out_bit, out_valid, sof, stuff_err, bus_idle, frame_active, stuff_cnt
  );

  modport slave (
    input  bit_in, bit_valid, stuff_stop,
    output out_bit, out_valid, sof, stuff_err, bus_idle, frame_active, stuff_cnt
  );
endinterface

// File: rtl/can_destuffer.sv
// CAN bit destuffer: integrates onto the bus, strips stuff bits up to the CRC,
// then passes the frame tail through until the bus goes idle again.
module can_destuffer #(
  parameter int STUFF_LEN = 5,
  parameter int IDLE_BITS = 11
) (
  input logic           clk,
  input logic           rst,
  can_destuffer_if.slave bus
);

  localparam int REC_W = $clog2(IDLE_BITS) + 1;
  localparam int RUN_W = $clog2(STUFF_LEN) + 1;

  typedef enum logic [1:0] {SYNC, IDLE, ACTIVE, TAIL} state_t;

  function automatic logic [REC_W-1:0] sat_inc_rec(input logic [REC_W-1:0] v);
    return (v == '1) ? v : v + REC_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    return (v == '1) ? v : v + RUN_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state_p0, state_nxt;
  logic [REC_W-1:0] rec_cnt_p0, rec_cnt_nxt, rec_up;
  logic [RUN_W-1:0] run_cnt_p0, run_cnt_nxt;
  logic             last_p0, last_nxt;
  logic [7:0]       stuff_cnt_p0, stuff_cnt_nxt;
  logic             out_bit_p1, out_bit_nxt;
  logic             vld_p1, vld_nxt;
  logic             sof_p1, sof_nxt;
  logic             err_p1, err_nxt;

  assign rec_up = sat_inc_rec(rec_cnt_p0);

  always_comb begin
    state_nxt     = state_p0;
    rec_cnt_nxt   = rec_cnt_p0;
    run_cnt_nxt   = run_cnt_p0;
    last_nxt      = last_p0;
    stuff_cnt_nxt = stuff_cnt_p0;
    out_bit_nxt   = out_bit_p1;
    vld_nxt       = 1'b0;
    sof_nxt       = 1'b0;
    err_nxt       = 1'b0;
    if (bus.bit_valid) begin
      unique case (state_p0)
        SYNC: begin
          if (bus.bit_in) begin
            rec_cnt_nxt = rec_up;
            if (rec_up >= REC_W'(IDLE_BITS)) begin
              state_nxt   = IDLE;
              rec_cnt_nxt = '0;
            end
          end else begin
            rec_cnt_nxt = '0;
          end
        end
        IDLE: begin
          if (!bus.bit_in) begin
            sof_nxt       = 1'b1;
            vld_nxt       = 1'b1;
            out_bit_nxt   = 1'b0;
            run_cnt_nxt   = RUN_W'(1);
            last_nxt      = 1'b0;
            stuff_cnt_nxt = 8'd0;
            state_nxt     = ACTIVE;
          end
        end
        ACTIVE: begin
          if (run_cnt_p0 == RUN_W'(STUFF_LEN)) begin
            // The stuff bit is dropped but still opens the next run.
            if (bus.bit_in != last_p0) begin
              run_cnt_nxt   = RUN_W'(1);
              last_nxt      = bus.bit_in;
              stuff_cnt_nxt = sat_inc8(stuff_cnt_p0);
              if (bus.stuff_stop) begin
                state_nxt   = TAIL;
                rec_cnt_nxt = '0;
              end
            end else begin
              err_nxt     = 1'b1;
              state_nxt   = SYNC;
              rec_cnt_nxt = '0;
            end
          end else begin
            vld_nxt     = 1'b1;
            out_bit_nxt = bus.bit_in;
            if (bus.bit_in == last_p0) begin
              run_cnt_nxt = sat_inc_run(run_cnt_p0);
            end else begin
              run_cnt_nxt = RUN_W'(1);
              last_nxt    = bus.bit_in;
            end
            if (bus.stuff_stop) begin
              state_nxt   = TAIL;
              rec_cnt_nxt = '0;
            end
          end
        end
        TAIL: begin
          vld_nxt     = 1'b1;
          out_bit_nxt = bus.bit_in;
          if (bus.bit_in) begin
            rec_cnt_nxt = rec_up;
            if (rec_up >= REC_W'(IDLE_BITS)) begin
              state_nxt   = IDLE;
              rec_cnt_nxt = '0;
            end
          end else begin
            rec_cnt_nxt = '0;
          end
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  // Stage p0 -> p1: state, counters and registered output strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0     <= SYNC;
      rec_cnt_p0   <= '0;
      run_cnt_p0   <= '0;
      last_p0      <= 1'b1;
      stuff_cnt_p0 <= 8'd0;
      vld_p1       <= 1'b0;
      sof_p1       <= 1'b0;
      err_p1       <= 1'b0;
    end else begin
      state_p0     <= state_nxt;
      rec_cnt_p0   <= rec_cnt_nxt;
      run_cnt_p0   <= run_cnt_nxt;
      last_p0      <= last_nxt;
      stuff_cnt_p0 <= stuff_cnt_nxt;
      vld_p1       <= vld_nxt;
      sof_p1       <= sof_nxt;
      err_p1       <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    out_bit_p1 <= out_bit_nxt;
  end

  assign bus.out_bit      = out_bit_p1;
  assign bus.out_valid    = vld_p1;
  assign bus.sof          = sof_p1;
  assign bus.stuff_err    = err_p1;
  assign bus.bus_idle     = (state_p0 == IDLE);
  assign bus.frame_active = (state_p0 == ACTIVE) || (state_p0 == TAIL);
  assign bus.stuff_cnt    = stuff_cnt_p0;

endmodule

// File: tb/tb_can_destuffer.sv
// Scoreboard bench for can_destuffer: expected destuffed bits are queued as
// stimulus is driven and popped by a monitor on every out_valid strobe.
module tb_can_destuffer;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   err_seen = 0;

  typedef struct packed {
    logic b;
    logic sof;
  } exp_t;

  exp_t sb_q[$];

  can_destuffer_if dut_if ();

  can_destuffer #(.STUFF_LEN(5), .IDLE_BITS(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
  endtask

  // Inputs change #1 after the rising edge; checks run at that point too.
  task automatic send_bit(input logic b, input logic stop);
    dut_if.bit_in     = b;
    dut_if.bit_valid  = 1'b1;
    dut_if.stuff_stop = stop;
    @(posedge clk); #1;
    dut_if.bit_valid  = 1'b0;
    dut_if.stuff_stop = 1'b0;
  endtask

  task automatic gap();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic b, input logic s);
    exp_t e;
    e.b = b;
    e.sof = s;
    sb_q.push_back(e);
  endtask

  task automatic integrate();
    for (int i = 0; i < 11; i++) begin
      send_bit(1'b1, 1'b0);
      gap();
    end
  endtask

  always @(negedge clk) begin
    if (dut_if.stuff_err) err_seen++;
    if (dut_if.sof && !dut_if.out_valid) chk("sof_without_valid", 1, 0);
    if (dut_if.out_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_bit", dut_if.out_bit, e.b);
        chk("sof", dut_if.sof, e.sof);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst = 1'b1;
    dut_if.bit_in = 1'b0;
    dut_if.bit_valid = 1'b1;
    dut_if.stuff_stop = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    dut_if.bit_valid = 1'b0;
    dut_if.stuff_stop = 1'b0;
    chk("rst_out_valid", dut_if.out_valid, 0);
    chk("rst_sof", dut_if.sof, 0);
    chk("rst_stuff_err", dut_if.stuff_err, 0);
    chk("rst_bus_idle", dut_if.bus_idle, 0);
    chk("rst_frame_active", dut_if.frame_active, 0);
    chk("rst_stuff_cnt", dut_if.stuff_cnt, 0);

    // Integration, with a dominant bit part-way through clearing the count
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b1, 1'b0);
      gap();
    end
    chk("sync_10_bus_idle", dut_if.bus_idle, 0);
    send_bit(1'b1, 1'b0);
    chk("sync_11_bus_idle", dut_if.bus_idle, 1);
    chk("sync_11_frame_active", dut_if.frame_active, 0);

    // stuff_stop while idle is ignored
    send_bit(1'b1, 1'b1);
    chk("idle_stop_bus_idle", dut_if.bus_idle, 1);
    chk("idle_stop_frame_active", dut_if.frame_active, 0);

    // SOF and a single stuff bit
    push(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0);
    push(1'b1, 1'b0);
    push(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    gap();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    gap();
    chk("destuff_stuff_cnt", dut_if.stuff_cnt, 1);
    chk("destuff_frame_active", dut_if.frame_active, 1);
    chk("destuff_sb_empty", sb_q.size(), 0);

    // Tail: stop with a data bit, then 1x6, 0, then 11 recessive to idle
    push(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      push(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
    end
    push(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      push(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
    end
    chk("tail_10_bus_idle", dut_if.bus_idle, 0);
    chk("tail_10_frame_active", dut_if.frame_active, 1);
    push(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    gap();
    chk("tail_11_bus_idle", dut_if.bus_idle, 1);
    chk("tail_11_frame_active", dut_if.frame_active, 0);
    chk("tail_stuff_cnt_held", dut_if.stuff_cnt, 1);
    chk("tail_sb_empty", sb_q.size(), 0);

    // Stuff bit opens the next run: 0x5, 1(stuff), 1x4, 0(stuff)
    push(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    gap();
    chk("run_stuff_cnt", dut_if.stuff_cnt, 2);
    chk("run_sb_empty", sb_q.size(), 0);

    // Reset mid-frame: the same-cycle bit would otherwise be a stuff error
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
    end
    e0 = err_seen;
    rst = 1'b1;
    dut_if.bit_in = 1'b0;
    dut_if.bit_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dut_if.bit_valid = 1'b0;
    chk("mid_rst_out_valid", dut_if.out_valid, 0);
    chk("mid_rst_stuff_err", dut_if.stuff_err, 0);
    chk("mid_rst_frame_active", dut_if.frame_active, 0);
    chk("mid_rst_bus_idle", dut_if.bus_idle, 0);
    chk("mid_rst_stuff_cnt", dut_if.stuff_cnt, 0);
    gap();
    chk("mid_rst_no_err_pulse", err_seen - e0, 0);

    // Stuff error: six dominant bits from idle
    integrate();
    chk("err_pre_bus_idle", dut_if.bus_idle, 1);
    e0 = err_seen;
    push(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("err_pulse", dut_if.stuff_err, 1);
    chk("err_out_valid", dut_if.out_valid, 0);
    gap();
    chk("err_pulse_once", err_seen - e0, 1);
    chk("err_bus_idle", dut_if.bus_idle, 0);
    chk("err_frame_active", dut_if.frame_active, 0);
    chk("err_stuff_cnt", dut_if.stuff_cnt, 0);
    chk("err_sb_empty", sb_q.size(), 0);

    // Recovery after the error
    integrate();
    chk("recover_bus_idle", dut_if.bus_idle, 1);
    repeat (2) gap();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
